// File: rtl/tile_router_v1_00_a_output_port.sv
// tile_router_v1_00_a_output_port: round-robin arbiter feeding a 2-entry output FIFO
module tile_router_v1_00_a_output_port #(
  parameter int C_NUM_REQUESTERS = 5,
  parameter int C_PACKET_WIDTH = 66
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [C_NUM_REQUESTERS-1:0]                reqX_valid,
  output logic [C_NUM_REQUESTERS-1:0]                reqX_accept,
  input  logic [C_NUM_REQUESTERS*C_PACKET_WIDTH-1:0] reqX_payload,
  output logic                                       output_valid,
  input  logic                                       output_accept,
  output logic [C_PACKET_WIDTH-1:0]                  output_payload
);
  localparam int N = C_NUM_REQUESTERS;
  localparam int W = C_PACKET_WIDTH;
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [1:0] count;
  logic rd_ptr, wr_ptr;
  logic [PW-1:0] ptr, grant, ptr_nxt;
  logic [W-1:0] mem [2];
  logic [W-1:0] sel;
  logic found, space, push, pop;
  // Search from the rr pointer upward, wrapping; the lowest offset wins, and mux its payload
  always_comb begin
    grant = '0;
    found = 1'b0;
    sel = '0;
    for (int k = N - 1; k >= 0; k--)
      if (reqX_valid[PW'((int'(ptr) + k) % N)]) begin
        grant = PW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    for (int i = 0; i < N; i++)
      if (grant == PW'(i)) sel = reqX_payload[i*W +: W];
  end
  assign space = count < 2'd2;
  assign push = rst && space && found;
  assign pop = output_valid && output_accept;
  assign reqX_accept = push ? N'(1) << grant : '0;
  assign ptr_nxt = grant == PW'(N - 1) ? '0 : grant + PW'(1);
  assign output_valid = count != 2'd0;
  assign output_payload = output_valid ? mem[rd_ptr] : '0;
  // FIFO storage, pointers and rr pointer; the rr pointer only advances on a push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      ptr <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sel;
        wr_ptr <= ~wr_ptr;
        ptr <= ptr_nxt;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_tile_router_v1_00_a_output_port.sv
// tb_tile_router_v1_00_a_output_port: directed scoreboard bench for the output port
module tb_tile_router_v1_00_a_output_port;
  localparam int N = 5;
  localparam int W = 66;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] reqX_valid = '0;
  logic [N-1:0] reqX_accept;
  logic [N*W-1:0] reqX_payload = '0;
  logic output_valid;
  logic output_accept = 1'b0;
  logic [W-1:0] output_payload;
  logic [W-1:0] q[$];
  int mptr = 0;
  int errors = 0;
  int checks = 0;

  tile_router_v1_00_a_output_port #(.C_NUM_REQUESTERS(N), .C_PACKET_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .reqX_valid(reqX_valid), .reqX_accept(reqX_accept),
    .reqX_payload(reqX_payload), .output_valid(output_valid),
    .output_accept(output_accept), .output_payload(output_payload)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pl(input int i, input logic [W-1:0] v);
    reqX_payload[i*W +: W] = v;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock: compare at the negedge against the model, then advance the model.
  task automatic cyc(input string tag);
    int g;
    logic [N-1:0] ea;
    logic [W-1:0] pl;
    @(negedge clk);
    g = pick(reqX_valid, mptr);
    ea = (rst && q.size() < 2 && g >= 0) ? N'(1) << g : '0;
    chk({tag, "_acc"}, 128'(reqX_accept), 128'(ea));
    chk({tag, "_ov"}, 128'(output_valid), 128'(q.size() != 0));
    chk({tag, "_pl"}, 128'(output_payload), q.size() != 0 ? 128'(q[0]) : 128'(0));
    if (rst && q.size() != 0 && output_accept) void'(q.pop_front());
    if (ea != '0) begin
      pl = reqX_payload[g*W +: W];
      q.push_back(pl);
      mptr = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset with all requesters valid
    reqX_valid = '1;
    for (int i = 0; i < N; i++) set_pl(i, W'(32'h100 + i));
    #1;
    chk("rst_acc", 128'(reqX_accept), 128'(0));
    chk("rst_ov", 128'(output_valid), 128'(0));
    chk("rst_pl", 128'(output_payload), 128'(0));
    cyc("rst_c0");
    cyc("rst_c1");
    rst = 1'b1;
    #1;
    chk("rel_acc", 128'(reqX_accept), 128'(5'b00001));
    cyc("rel_c0");
    reqX_valid = '0;
    output_accept = 1'b1;
    for (int i = 0; i < 3; i++) cyc("drain1");
    // 2. Single pass-through from req2
    reqX_valid = 5'b00100;
    set_pl(2, W'(12'h0AB));
    #1;
    chk("pass_acc", 128'(reqX_accept), 128'(5'b00100));
    cyc("pass_c0");
    reqX_valid = '0;
    #1;
    chk("pass_ov", 128'(output_valid), 128'(1));
    chk("pass_pl", 128'(output_payload), 128'(12'h0AB));
    cyc("pass_c1");
    cyc("pass_c2");
    // 3. Round-robin among req0, req1, req3 with no bubbles
    set_pl(0, W'(8'h10));
    set_pl(1, W'(8'h11));
    set_pl(3, W'(8'h13));
    reqX_valid = 5'b01011;
    for (int i = 0; i < 8; i++) cyc("rr");
    reqX_valid = '0;
    for (int i = 0; i < 2; i++) cyc("drain3");
    // 4. Backpressure on req4, then release
    output_accept = 1'b0;
    set_pl(4, W'(8'h44));
    reqX_valid = 5'b10000;
    for (int i = 0; i < 4; i++) cyc("bp");
    chk("bp_full_acc", 128'(reqX_accept), 128'(0));
    chk("bp_hold_pl", 128'(output_payload), 128'(8'h44));
    output_accept = 1'b1;
    for (int i = 0; i < 3; i++) cyc("bp_rel");
    reqX_valid = '0;
    for (int i = 0; i < 3; i++) cyc("drain4");
    // 5. Wrap: serve req3 so the pointer sits at 4, then req4 beats req1
    reqX_valid = 5'b01000;
    cyc("wrap_r3");
    reqX_valid = 5'b10010;
    #1;
    chk("wrap_acc4", 128'(reqX_accept), 128'(5'b10000));
    cyc("wrap_c0");
    #1;
    chk("wrap_acc1", 128'(reqX_accept), 128'(5'b00010));
    cyc("wrap_c1");
    reqX_valid = '0;
    for (int i = 0; i < 3; i++) cyc("drain5");
    // 6. Reset mid-stream with a full FIFO
    output_accept = 1'b0;
    set_pl(0, W'(8'h55));
    reqX_valid = 5'b00001;
    for (int i = 0; i < 3; i++) cyc("fill");
    chk("full_ov", 128'(output_valid), 128'(1));
    rst = 1'b0;
    #1;
    chk("mid_ov", 128'(output_valid), 128'(0));
    chk("mid_pl", 128'(output_payload), 128'(0));
    chk("mid_acc", 128'(reqX_accept), 128'(0));
    q.delete();
    mptr = 0;
    cyc("mid_c0");
    rst = 1'b1;
    reqX_valid = '0;
    output_accept = 1'b1;
    for (int i = 0; i < 2; i++) cyc("post");
    reqX_valid = '1;
    #1;
    chk("post_acc", 128'(reqX_accept), 128'(5'b00001));
    for (int i = 0; i < 3; i++) cyc("post_rr");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
